// File: rtl/dff_pipe_stage.sv
// One register slice of dff_pipe: a WIDTH-bit data register plus its valid bit.
// The top decides when the slice loads. A load with src_v=0 empties the slice
// but leaves the data register alone, so bubbles never disturb data.
module dff_pipe_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             src_v,
  input  logic [WIDTH-1:0] src_d,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  // Valid follows the source whenever loading; data only captures real words.
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= 1'b0;
      d <= RESET_VAL;
    end else if (load) begin
      v <= src_v;
      if (src_v) d <= src_d;
    end
  end

endmodule

// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH-bit, DEPTH-stage register pipeline with valid/ready on both
// ends. Stalls propagate backwards through a combinational ready chain, and
// empty stages in front of a stall keep filling (bubble collapse). A flush
// empties every stage in one edge without touching data; reset also restores
// the data registers. count tracks the number of occupied stages.
module dff_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  // Stage state; index DEPTH-1 is the output stage.
  logic [DEPTH-1:0]            vld_pipe;
  logic [DEPTH-1:0][WIDTH-1:0] dat_pipe;

  // Per-stage source and load controls.
  logic [DEPTH-1:0]            src_v;
  logic [DEPTH-1:0][WIDTH-1:0] src_d;
  logic [DEPTH-1:0]            load;

  // rdy[i]: stage i may take a new value this cycle. rdy[DEPTH] is the consumer.
  logic [DEPTH:0]              rdy;

  logic                        in_xfer;
  logic                        out_xfer;
  logic [CW-1:0]               cnt;

  // Ready chain, walked from the output back to the input. A stage is ready if
  // it is empty or the stage ahead of it is ready; this is a DEPTH-long
  // combinational path by design, kept in one block so it evaluates in order.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = out_ready;
    for (int i = DEPTH-1; i >= 0; i--) begin
      rdy[i] = !vld_pipe[i] || rdy[i+1];
    end
  end

  assign in_ready  = rdy[0] && !flush;
  assign out_valid = vld_pipe[DEPTH-1];
  assign out_data  = dat_pipe[DEPTH-1];

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // Stage array. Flush forces every stage to load a bubble, which clears all
  // valids in one edge while leaving the data registers untouched.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign src_v[i] = in_valid && !flush;
      assign src_d[i] = in_data;
    end else begin : g_body
      assign src_v[i] = vld_pipe[i-1] && !flush;
      assign src_d[i] = dat_pipe[i-1];
    end

    assign load[i] = rdy[i] || flush;

    dff_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .load  (load[i]),
      .src_v (src_v[i]),
      .src_d (src_d[i]),
      .v     (vld_pipe[i]),
      .d     (dat_pipe[i])
    );
  end

  // Occupancy: +1 on an input-only transfer, -1 on an output-only transfer.
  // A flush empties the pipe, so the count returns to zero with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (in_xfer && !out_xfer) begin
      cnt <= cnt + CW'(1);
    end else if (!in_xfer && out_xfer) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign count = cnt;

endmodule
